// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM command encodings, bus widths and the owner type used by the
// two-port SDRAM arbiter and its grant mux.
package sdram_port_arbiter_pkg;

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   localparam int READ_BURST_LENGTH = 8;
   localparam int ADDR_W            = 22;
   localparam int DATA_W            = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   function automatic logic is_pending(input logic [1:0] command);
      return command != CMD_IDLE;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client, controller and status signals of the two-port SDRAM arbiter.
// The slave modport is the arbiter's view; master is the clients/controller view.
interface sdram_port_arbiter_if;
   import sdram_port_arbiter_pkg::*;

   logic [1:0]        i_P0_Command;
   logic [ADDR_W-1:0] i_P0_Address;
   logic [DATA_W-1:0] i_P0_Data_Write;
   logic              o_P0_Granted;
   logic              o_P0_Data_Read_Valid;
   logic              o_P0_Data_Write_Done;

   logic [1:0]        i_P1_Command;
   logic [ADDR_W-1:0] i_P1_Address;
   logic [DATA_W-1:0] i_P1_Data_Write;
   logic              o_P1_Granted;
   logic              o_P1_Data_Read_Valid;
   logic              o_P1_Data_Write_Done;
   logic              o_P1_SDRAM_Requested;
   logic              i_P1_SDRAM_Yield;

   logic [1:0]        o_Command;
   logic [ADDR_W-1:0] o_Data_Address;
   logic [DATA_W-1:0] o_Data_Write;
   logic              i_Data_Read_Valid;
   logic              i_Data_Write_Done;
   logic              o_Timeout;

   modport slave (
      input  i_P0_Command, i_P0_Address, i_P0_Data_Write,
             i_P1_Command, i_P1_Address, i_P1_Data_Write, i_P1_SDRAM_Yield,
             i_Data_Read_Valid, i_Data_Write_Done,
      output o_P0_Granted, o_P0_Data_Read_Valid, o_P0_Data_Write_Done,
             o_P1_Granted, o_P1_Data_Read_Valid, o_P1_Data_Write_Done,
             o_P1_SDRAM_Requested, o_Command, o_Data_Address, o_Data_Write,
             o_Timeout
   );

   modport master (
      output i_P0_Command, i_P0_Address, i_P0_Data_Write,
             i_P1_Command, i_P1_Address, i_P1_Data_Write, i_P1_SDRAM_Yield,
             i_Data_Read_Valid, i_Data_Write_Done,
      input  o_P0_Granted, o_P0_Data_Read_Valid, o_P0_Data_Write_Done,
             o_P1_Granted, o_P1_Data_Read_Valid, o_P1_Data_Write_Done,
             o_P1_SDRAM_Requested, o_Command, o_Data_Address, o_Data_Write,
             o_Timeout
   );

endinterface

// File: rtl/sdram_grant_mux.sv
// Combinational command/address/data mux toward the SDRAM controller and
// strobe demux back to whichever port currently owns it.
module sdram_grant_mux
   import sdram_port_arbiter_pkg::*;
(
   input  owner_e            owner,
   input  logic [1:0]        p0_command,
   input  logic [ADDR_W-1:0] p0_address,
   input  logic [DATA_W-1:0] p0_data_write,
   input  logic [1:0]        p1_command,
   input  logic [ADDR_W-1:0] p1_address,
   input  logic [DATA_W-1:0] p1_data_write,
   input  logic              data_read_valid,
   input  logic              data_write_done,
   output logic [1:0]        command,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data_write,
   output logic              p0_read_valid,
   output logic              p0_write_done,
   output logic              p1_read_valid,
   output logic              p1_write_done
);

   // With no owner the controller sees an idle, all-zero request.
   always_comb begin
      command    = CMD_IDLE;
      address    = '0;
      data_write = '0;
      case (owner)
         OWN_P0: begin
            command    = p0_command;
            address    = p0_address;
            data_write = p0_data_write;
         end
         OWN_P1: begin
            command    = p1_command;
            address    = p1_address;
            data_write = p1_data_write;
         end
         default: ;
      endcase
   end

   assign p0_read_valid = data_read_valid && (owner == OWN_P0);
   assign p0_write_done = data_write_done && (owner == OWN_P0);
   assign p1_read_valid = data_read_valid && (owner == OWN_P1);
   assign p1_write_done = data_write_done && (owner == OWN_P1);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM command arbiter: display reader (port 0) has priority, the
// compute engine (port 1) is preempted by handshake, guarded against starvation.
module sdram_port_arbiter
   import sdram_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 255,
   parameter int WATCHDOG     = 1023
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   sdram_port_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      NONE      = 2'd0,
      GRANT_P0  = 2'd1,
      GRANT_P1  = 2'd2,
      REVOKE_P1 = 2'd3
   } state_e;

   localparam logic [7:0]      STARVE_MAX = 8'(STARVE_LIMIT);
   localparam int              WD_W       = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
   localparam logic [WD_W-1:0] WD_LAST    = (WATCHDOG > 0) ? WD_W'(WATCHDOG - 1) : '0;
   localparam bit              WD_EN      = (WATCHDOG > 0);

   state_e          state, state_next;
   logic [7:0]      starve_cnt, starve_next;
   logic            protect, protect_next;
   logic [WD_W-1:0] wd_cnt, wd_next;
   logic            timeout_q;
   owner_e          owner;

   logic p0_pending, p1_pending, starve_win, strobe, in_grant, wd_fire;

   assign p0_pending = is_pending(bus.i_P0_Command);
   assign p1_pending = is_pending(bus.i_P1_Command);
   assign in_grant   = (state != NONE);
   assign strobe     = bus.i_Data_Read_Valid || bus.i_Data_Write_Done;
   assign starve_win = p1_pending && (starve_cnt == STARVE_MAX);
   assign wd_fire    = WD_EN && in_grant && !strobe && (wd_cnt == WD_LAST);

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state      <= NONE;
         starve_cnt <= '0;
         protect    <= 1'b0;
         wd_cnt     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         protect    <= protect_next;
         wd_cnt     <= wd_next;
         timeout_q  <= wd_fire;
      end
   end

   // Every grant passes through NONE, so a handover always costs one idle cycle.
   always_comb begin
      state_next   = state;
      protect_next = protect;
      case (state)
         NONE: begin
            protect_next = starve_win;
            if (starve_win)      state_next = GRANT_P1;
            else if (p0_pending) state_next = GRANT_P0;
            else if (p1_pending) state_next = GRANT_P1;
         end
         GRANT_P0: begin
            if (!p0_pending) state_next = NONE;
         end
         GRANT_P1: begin
            if (!p1_pending)                  state_next = NONE;
            else if (p0_pending && !protect)  state_next = REVOKE_P1;
         end
         REVOKE_P1: begin
            if (bus.i_P1_SDRAM_Yield || !p1_pending) state_next = NONE;
         end
         default: state_next = NONE;
      endcase
      if (wd_fire) state_next = NONE;
      if (state_next != GRANT_P1) protect_next = 1'b0;
   end

   // Starvation credit saturates at the limit; the watchdog restarts on any strobe or phase change.
   always_comb begin
      starve_next = starve_cnt;
      if (state == GRANT_P1 || state == REVOKE_P1)
         starve_next = '0;
      else if (p1_pending && starve_cnt != STARVE_MAX)
         starve_next = starve_cnt + 8'd1;

      wd_next = '0;
      if (WD_EN && in_grant && !strobe && state_next == state)
         wd_next = wd_cnt + WD_W'(1);
   end

   always_comb begin
      owner = OWN_NONE;
      case (state)
         GRANT_P0:            owner = OWN_P0;
         GRANT_P1, REVOKE_P1: owner = OWN_P1;
         default:             owner = OWN_NONE;
      endcase
   end

   assign bus.o_P0_Granted         = (owner == OWN_P0);
   assign bus.o_P1_Granted         = (owner == OWN_P1);
   assign bus.o_P1_SDRAM_Requested = (state == REVOKE_P1);
   assign bus.o_Timeout            = timeout_q;

   sdram_grant_mux u_grant_mux (
      .owner           (owner),
      .p0_command      (bus.i_P0_Command),
      .p0_address      (bus.i_P0_Address),
      .p0_data_write   (bus.i_P0_Data_Write),
      .p1_command      (bus.i_P1_Command),
      .p1_address      (bus.i_P1_Address),
      .p1_data_write   (bus.i_P1_Data_Write),
      .data_read_valid (bus.i_Data_Read_Valid),
      .data_write_done (bus.i_Data_Write_Done),
      .command         (bus.o_Command),
      .address         (bus.o_Data_Address),
      .data_write      (bus.o_Data_Write),
      .p0_read_valid   (bus.o_P0_Data_Read_Valid),
      .p0_write_done   (bus.o_P0_Data_Write_Done),
      .p1_read_valid   (bus.o_P1_Data_Read_Valid),
      .p1_write_done   (bus.o_P1_Data_Write_Done)
   );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scoreboard bench for sdram_port_arbiter: two bursting clients and a
// controller model drive the DUT while an ownership-level model predicts every cycle.
module tb_sdram_port_arbiter;
   import sdram_port_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;
   localparam int WATCHDOG     = 16;
   localparam int NUM_CYCLES   = 3000;

   logic i_Clk = 1'b0;
   logic i_Rst_n;
   always #5 i_Clk = ~i_Clk;

   sdram_port_arbiter_if bus ();

   sdram_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .WATCHDOG     (WATCHDOG)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .bus     (bus)
   );

   typedef struct {
      int          cyc;
      logic [2:0]  grant;     // {P0 granted, P1 granted, P1 requested}
      logic [55:0] ctrl;      // {command, address, write data}
      logic [3:0]  strobes;   // {P0 read, P0 write, P1 read, P1 write}
      logic        timeout;
   } exp_t;

   typedef struct {
      bit          busy;
      logic [1:0]  cmd;
      logic [21:0] addr;
      int          beats;
   } client_t;

   exp_t    exp_q[$];
   client_t cl0, cl1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: who owns the controller, and event timestamps.
   int m_owner;          // 0 nobody, 1 port 0, 2 port 1
   bit m_ask;            // port 1 has been asked to yield
   bit m_shield;         // current port 1 grant was won by starvation
   int m_p1_wait;
   int m_phase_start;
   int m_last_strobe;
   bit m_timeout;
   bit hang;
   int owner_before;
   int n_timeouts = 0, n_revokes = 0, n_shielded = 0;

   task automatic checkValue(input string name, input int c,
                             input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, c, got, exp);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checkValue("grant/requested", e.cyc,
                 64'({bus.o_P0_Granted, bus.o_P1_Granted, bus.o_P1_SDRAM_Requested}), 64'(e.grant));
      checkValue("controller mux", e.cyc,
                 64'({bus.o_Command, bus.o_Data_Address, bus.o_Data_Write}), 64'(e.ctrl));
      checkValue("strobe routing", e.cyc,
                 64'({bus.o_P0_Data_Read_Valid, bus.o_P0_Data_Write_Done,
                      bus.o_P1_Data_Read_Valid, bus.o_P1_Data_Write_Done}), 64'(e.strobes));
      checkValue("timeout", e.cyc, 64'(bus.o_Timeout), 64'(e.timeout));
   endtask

   task automatic modelReset();
      m_owner       = 0;
      m_ask         = 0;
      m_shield      = 0;
      m_p1_wait     = 0;
      m_timeout     = 0;
      m_phase_start = cyc;
      m_last_strobe = cyc - 1;
      hang          = 0;
      cl0.busy = 0; cl0.beats = 0; cl0.cmd = CMD_IDLE; cl0.addr = '0;
      cl1.busy = 0; cl1.beats = 0; cl1.cmd = CMD_IDLE; cl1.addr = '0;
   endtask

   task automatic driveIdle();
      bus.i_P0_Command      = CMD_IDLE;
      bus.i_P0_Address      = '0;
      bus.i_P0_Data_Write   = '0;
      bus.i_P1_Command      = CMD_IDLE;
      bus.i_P1_Address      = '0;
      bus.i_P1_Data_Write   = '0;
      bus.i_P1_SDRAM_Yield  = 1'b0;
      bus.i_Data_Read_Valid = 1'b0;
      bus.i_Data_Write_Done = 1'b0;
   endtask

   task automatic startBurst(inout client_t c);
      c.busy  = 1;
      c.cmd   = ($urandom_range(1) == 0) ? CMD_READ : CMD_WRITE;
      c.addr  = 22'($urandom);
      c.beats = 0;
   endtask

   // One cycle: clients and controller react to the model, expectation is queued, model advances.
   task automatic applyStimulus();
      exp_t        e;
      logic [1:0]  cmd0, cmd1, ecmd;
      logic [21:0] addr0, addr1, eaddr;
      logic [31:0] d0, d1, edata;
      logic        rv, wd, yield;
      bit          asked, p0p, p1p, strobe_now, fired, next_ask, next_shield;
      int          rate0, next_owner, silent, quiet_from;

      asked = (m_owner == 2) && m_ask;
      case ((cyc / 250) % 3)
         0:       rate0 = 50;
         1:       rate0 = 90;
         default: rate0 = 12;
      endcase

      if (cl0.busy && cl0.beats >= READ_BURST_LENGTH) cl0.busy = 0;
      else if (!cl0.busy && $urandom_range(99) < rate0) startBurst(cl0);

      yield = 1'b0;
      if (cl1.busy && cl1.beats >= READ_BURST_LENGTH) begin
         if (asked && $urandom_range(1) == 1) begin
            yield = 1'b1;
            startBurst(cl1);
         end else begin
            cl1.busy = 0;
         end
      end else if (!cl1.busy && $urandom_range(99) < 30) begin
         startBurst(cl1);
      end
      if (!asked && $urandom_range(9) == 0) yield = 1'b1;

      cmd0  = cl0.busy ? cl0.cmd : CMD_IDLE;
      addr0 = cl0.busy ? cl0.addr : 22'($urandom);
      cmd1  = cl1.busy ? cl1.cmd : CMD_IDLE;
      addr1 = cl1.busy ? cl1.addr : 22'($urandom);
      d0    = $urandom;
      d1    = $urandom;

      ecmd = CMD_IDLE; eaddr = '0; edata = '0;
      if (m_owner == 1) begin ecmd = cmd0; eaddr = addr0; edata = d0; end
      if (m_owner == 2) begin ecmd = cmd1; eaddr = addr1; edata = d1; end

      if (m_owner == 0) hang = 0;
      else if (cyc == m_phase_start) hang = ($urandom_range(7) == 0);
      rv = 1'b0; wd = 1'b0;
      if (m_owner != 0 && !hang && ecmd != CMD_IDLE && $urandom_range(2) != 0) begin
         rv = (ecmd == CMD_READ);
         wd = (ecmd == CMD_WRITE);
      end else if (!hang && $urandom_range(15) == 0) begin
         if ($urandom_range(1) == 0) rv = 1'b1;
         else                        wd = 1'b1;
      end

      bus.i_P0_Command      = cmd0;
      bus.i_P0_Address      = addr0;
      bus.i_P0_Data_Write   = d0;
      bus.i_P1_Command      = cmd1;
      bus.i_P1_Address      = addr1;
      bus.i_P1_Data_Write   = d1;
      bus.i_P1_SDRAM_Yield  = yield;
      bus.i_Data_Read_Valid = rv;
      bus.i_Data_Write_Done = wd;

      e.cyc     = cyc;
      e.grant   = {m_owner == 1, m_owner == 2, asked};
      e.ctrl    = {ecmd, eaddr, edata};
      e.strobes = {rv && m_owner == 1, wd && m_owner == 1, rv && m_owner == 2, wd && m_owner == 2};
      e.timeout = m_timeout;
      exp_q.push_back(e);

      if (m_owner == 1 && (rv || wd)) cl0.beats++;
      if (m_owner == 2 && (rv || wd)) cl1.beats++;

      p0p        = (cmd0 != CMD_IDLE);
      p1p        = (cmd1 != CMD_IDLE);
      strobe_now = rv || wd;
      quiet_from = (m_phase_start > m_last_strobe + 1) ? m_phase_start : m_last_strobe + 1;
      silent     = (m_owner != 0 && !strobe_now) ? cyc - quiet_from + 1 : 0;

      next_owner = m_owner; next_ask = m_ask; next_shield = m_shield; fired = 0;
      if (m_owner == 0) begin
         if (p1p && m_p1_wait >= STARVE_LIMIT) begin
            next_owner = 2; next_shield = 1; n_shielded++;
         end else if (p0p) next_owner = 1;
         else if (p1p)     next_owner = 2;
      end else if (m_owner == 1) begin
         if (!p0p) next_owner = 0;
      end else if (m_ask) begin
         if (yield || !p1p) next_owner = 0;
      end else if (!p1p) begin
         next_owner = 0;
      end else if (p0p && !m_shield) begin
         next_ask = 1; n_revokes++;
      end
      if (silent == WATCHDOG) begin
         next_owner = 0; fired = 1; n_timeouts++;
      end
      if (next_owner == 0) begin next_ask = 0; next_shield = 0; end

      if (m_owner == 2)                            m_p1_wait = 0;
      else if (p1p && m_p1_wait < STARVE_LIMIT)    m_p1_wait++;
      if (next_owner != m_owner || next_ask != m_ask) m_phase_start = cyc + 1;
      if (strobe_now) m_last_strobe = cyc;

      owner_before = m_owner;
      m_owner   = next_owner;
      m_ask     = next_ask;
      m_shield  = next_shield;
      m_timeout = fired;
      cyc++;
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear without a clock edge.
   task automatic doReset();
      #2;
      i_Rst_n = 1'b0;
      #1;
      checkValue("reset command", cyc, 64'(bus.o_Command), 64'(CMD_IDLE));
      checkValue("reset address/data", cyc, 64'({bus.o_Data_Address, bus.o_Data_Write}), 64'(0));
      checkValue("reset grants", cyc,
                 64'({bus.o_P0_Granted, bus.o_P1_Granted, bus.o_P1_SDRAM_Requested}), 64'(0));
      checkValue("reset strobes", cyc,
                 64'({bus.o_P0_Data_Read_Valid, bus.o_P0_Data_Write_Done,
                      bus.o_P1_Data_Read_Valid, bus.o_P1_Data_Write_Done}), 64'(0));
      checkValue("reset timeout", cyc, 64'(bus.o_Timeout), 64'(0));
      exp_q.delete();
      driveIdle();
      repeat (2) @(posedge i_Clk);
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      modelReset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_Clk);
         if (i_Rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : driver
      int next_reset;
      $display("[TB] sdram_port_arbiter random run, STARVE_LIMIT=%0d WATCHDOG=%0d", STARVE_LIMIT, WATCHDOG);
      driveIdle();
      i_Rst_n = 1'b1;
      #2;
      i_Rst_n = 1'b0;
      #1;
      checkValue("initial reset command", 0, 64'(bus.o_Command), 64'(CMD_IDLE));
      checkValue("initial reset grants", 0,
                 64'({bus.o_P0_Granted, bus.o_P1_Granted, bus.o_P1_SDRAM_Requested, bus.o_Timeout}), 64'(0));
      repeat (3) @(posedge i_Clk);
      @(negedge i_Clk);
      i_Rst_n = 1'b1;
      modelReset();

      next_reset = 1000;
      for (int n = 0; n < NUM_CYCLES; n++) begin
         @(posedge i_Clk);
         #1;
         applyStimulus();
         if (cyc >= next_reset && owner_before == 1 && cl0.beats > 0) begin
            $display("[TB] asynchronous reset during port 0 burst at cycle %0d", cyc - 1);
            doReset();
            next_reset = next_reset + 1000;
         end
      end
      repeat (2) @(negedge i_Clk);
      $display("[TB] model events: %0d timeouts, %0d revokes, %0d starvation grants",
               n_timeouts, n_revokes, n_shielded);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
